vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port, synchronous-read frame-buffer RAM between two users:
  - VGA scanout reads, which have absolute priority.
  - A pixel writer (drawing engine/CPU), which gets every cycle scanout does not use.
- Sits between vga_controller (consumes p_tick, video_on, x, y) and the block RAM.
- Converts 640x480 screen coordinates to a down-scaled frame-buffer address and produces the registered RGB pixel for the DAC pins.

Parameters:
- FB_W, 160, frame-buffer width in pixels.
- FB_H, 120, frame-buffer height in pixels.
- SCALE, 2, log2 of the screen-to-buffer scale factor (x>>SCALE, y>>SCALE).
- AW, 15, RAM address width; must satisfy 2^AW >= FB_W*FB_H.
- DW, 12, pixel width (4:4:4 RGB).

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- p_tick  in  1  25 MHz pixel tick; high 1 cycle in 4.
- video_on  in  1  display-area flag from vga_controller.
- x  in  10  pixel column, 0-799.
- y  in  10  pixel row, 0-524.
- wr_req  in  1  writer request; wr_addr/wr_data held stable until wr_ack.
- wr_addr  in  AW  writer buffer address.
- wr_data  in  DW  writer pixel.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  sticky: an out-of-range write was discarded.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after a read enable.
- rgb  out  DW  registered pixel output.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset: single clock, clk_100MHz. reset is synchronous and active-high.
- Reset values: rgb=0, wr_ack=0, wr_err=0, frame_start=0, mem_en=0, mem_we=0, pipeline valid bits=0, FSM=IDLE.
- Scan address: sx=x>>SCALE, sy=y>>SCALE, scan_addr=sy*FB_W+sx, computed in AW bits.
  - scan_hit = p_tick & video_on & (sx<FB_W) & (sy<FB_H).
- Priority: in a scan_hit cycle, mem_en=1, mem_we=0, mem_addr=scan_addr. The writer is never granted in that cycle.
- Scan pipeline:
  - Cycle N: read issued.
  - Cycle N+1: mem_rdata captured into the rgb register.
  - rgb changes at the start of N+2 and holds until the next capture.
- Blanking: if p_tick & ~scan_hit, a zero is pushed through the same 2-cycle pipeline, so rgb=0 from N+2.
  - Covers blanking and out-of-buffer coordinates.
  - No RAM access is made for these ticks.
- Write FSM, IDLE -> GRANT -> IDLE:
  - IDLE: if wr_req & ~scan_hit & wr_allowed, go to GRANT.
  - GRANT, in-range address (wr_addr < FB_W*FB_H): mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1, go to IDLE.
  - GRANT, out-of-range address: no RAM access; wr_ack=1 and wr_err set (sticky until reset).
  - A scan_hit arriving while in GRANT preempts the write. The scan read is issued, wr_ack stays 0, the FSM stays in GRANT, and the write retries next cycle.
- Write throughput: at most 1 write per 2 cycles. Guaranteed >=1 write per pixel period, since scan uses at most 1 of 4 cycles.
- wr_req dropped before wr_ack: the FSM returns to IDLE without a write. No ack is issued.
- Ordering: a write in cycle N+1 does not affect a read issued in cycle N. The RAM is read-first or no-change.
- frame_start=1 for one cycle, registered, the cycle after a cycle with p_tick & x==0 & y==0.
- Reset mid-operation: the in-flight write is dropped with no ack, the pipeline is flushed and rgb=0. The writer must re-request.
- wr_allowed=1 unless the optional feature below is compiled in.

Optional Feature:
- Macro: VGA_FB_VBLANK_WR_EN.
- Defined: wr_allowed = (y >= 480). Writes are granted only during vertical blanking, giving tear-free updates. A request made during active lines waits until y reaches 480.
- Undefined: wr_allowed=1. Writes interleave with scanout at any time.

Test Plan:
- Reset, then idle for 4 p_ticks: rgb=0, mem_en=0, wr_ack=0 throughout.
- Preload RAM address 0 with 12'hF00; x=0, y=0, video_on=1, p_tick pulse: mem_addr=0 with mem_en=1 in the tick cycle; rgb=12'hF00 two cycles later; frame_start pulses once.
- x=643, y=10, video_on=0, p_tick: no RAM access; rgb=0 at N+2.
- wr_req with wr_addr=161, wr_data=12'h0A5 asserted in the same cycle as a scan_hit: scan read first; write mem_we=1 at addr 161 follows; wr_ack one pulse; a later scan at x=4, y=4 returns 12'h0A5.
- wr_addr=19200: wr_ack pulses, mem_we stays 0, wr_err=1 and stays 1 until reset.
- With VGA_FB_VBLANK_WR_EN, wr_req at y=100: no wr_ack until y=480; the write then completes within 3 cycles.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: VGA scanout reads take absolute priority, a pixel writer gets the spare cycles.
// Optional build macro VGA_FB_VBLANK_WR_EN restricts writes to vertical blanking (y >= 480).
module vga_fb_arbiter #(
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int SCALE = 2,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic          frame_start
);

    localparam logic [9:0]  FB_W_X  = 10'(FB_W);
    localparam logic [9:0]  FB_H_Y  = 10'(FB_H);
    // One extra bit so the bound still fits when the buffer fills the whole address space
    localparam logic [AW:0] FB_SIZE = (AW+1)'(FB_W * FB_H);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [9:0]    sx;
    logic [9:0]    sy;
    logic [AW-1:0] scan_addr;
    logic          scan_hit;
    logic          wr_allowed;
    logic          wr_in_range;

    logic [0:0]    state_reg, state_next;
    logic          write_go;
    logic          ack_next;
    logic          err_set;

    logic          pipe_valid_reg;
    logic          pipe_hit_reg;
    logic [DW-1:0] rgb_reg;
    logic          frame_start_reg;
    logic          wr_err_reg;

    assign sx        = x >> SCALE;
    assign sy        = y >> SCALE;
    assign scan_addr = AW'(sy) * AW'(FB_W) + AW'(sx);
    assign scan_hit  = p_tick & video_on & (sx < FB_W_X) & (sy < FB_H_Y);

`ifdef VGA_FB_VBLANK_WR_EN
    assign wr_allowed = (y >= 10'd480);
`else
    assign wr_allowed = 1'b1;
`endif

    assign wr_in_range = ({1'b0, wr_addr} < FB_SIZE);

    // A scan hit in GRANT holds the FSM there so the write retries on the next free cycle
    always_comb begin
        state_next = state_reg;
        write_go   = 1'b0;
        ack_next   = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_req && !scan_hit && wr_allowed)
                    state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (!wr_req) begin
                    state_next = ST_IDLE;
                end else if (!scan_hit) begin
                    state_next = ST_IDLE;
                    ack_next   = 1'b1;
                    write_go   = wr_in_range;
                    err_set    = !wr_in_range;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_en    = !reset && (scan_hit || write_go);
    assign mem_we    = !reset && !scan_hit && write_go;
    assign mem_addr  = scan_hit ? scan_addr : wr_addr;
    assign mem_wdata = wr_data;
    assign wr_ack    = !reset && ack_next;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pipe_valid_reg  <= 1'b0;
            pipe_hit_reg    <= 1'b0;
            rgb_reg         <= '0;
            frame_start_reg <= 1'b0;
            wr_err_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pipe_valid_reg  <= p_tick;
            pipe_hit_reg    <= scan_hit;
            // Ticks without a RAM read push a black pixel through the same two-cycle path
            if (pipe_valid_reg)
                rgb_reg <= pipe_hit_reg ? mem_rdata : '0;
            frame_start_reg <= p_tick && (x == 10'd0) && (y == 10'd0);
            if (err_set)
                wr_err_reg <= 1'b1;
        end
    end

    assign rgb         = rgb_reg;
    assign frame_start = frame_start_reg;
    assign wr_err      = wr_err_reg;

endmodule
